pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 133 +++++++++++++
 tb/tb_pc_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered fetch-address sequencer with a circular return stack.
// Define PC_SEQ_STACK_ERR_EN to enable the sticky ovf/udf stack error flags.
module pc_sequencer #(
    parameter int ADDR_W      = 16,
    parameter int STACK_DEPTH = 16,
    parameter int JMP_W       = 13,
    parameter int INT_W       = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         jmp,
    input  logic [JMP_W-1:0]             jmp_target,
    input  logic                         branch,
    input  logic [ADDR_W-1:0]            branch_target,
    input  logic                         call,
    input  logic [ADDR_W-1:0]            call_target,
    input  logic                         ret,
    input  logic                         irq,
    input  logic [INT_W-1:0]             irq_num,
    input  logic [ADDR_W-1:0]            link_addr,
    input  logic                         clr_err,
    output logic [ADDR_W-1:0]            pc,
    output logic [$clog2(STACK_DEPTH):0] depth,
    output logic                         ovf,
    output logic                         udf
);

    localparam int PTR_W   = $clog2(STACK_DEPTH);
    localparam int DEPTH_W = PTR_W + 1;

    typedef enum logic [2:0] {
        SRC_INC,
        SRC_STALL,
        SRC_JMP,
        SRC_RET,
        SRC_BRANCH,
        SRC_CALL,
        SRC_IRQ
    } src_e;

    src_e               src;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_next;
    logic [PTR_W-1:0]   wp;
    logic [PTR_W-1:0]   wp_dec;
    logic [DEPTH_W-1:0] depth_q;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [ADDR_W-1:0]  stack_mem [STACK_DEPTH];

    always_comb begin
        src = SRC_INC;
        if (irq)         src = SRC_IRQ;
        else if (call)   src = SRC_CALL;
        else if (branch) src = SRC_BRANCH;
        else if (ret)    src = SRC_RET;
        else if (jmp)    src = SRC_JMP;
        else if (stall)  src = SRC_STALL;
    end

    assign push   = (src == SRC_IRQ) || (src == SRC_CALL);
    assign pop    = (src == SRC_RET);
    assign full   = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign empty  = (depth_q == '0);
    assign wp_dec = wp - 1'b1;

    always_comb begin
        pc_next = pc_q + 1'b1;
        unique case (src)
            SRC_IRQ:    pc_next = ADDR_W'(irq_num);
            SRC_CALL:   pc_next = call_target;
            SRC_BRANCH: pc_next = branch_target;
            SRC_RET:    pc_next = stack_mem[wp_dec];
            SRC_JMP:    pc_next = {pc_q[ADDR_W-1:JMP_W], jmp_target};
            SRC_STALL:  pc_next = pc_q;
            default:    pc_next = pc_q + 1'b1;
        endcase
    end

    // Full/empty only saturate depth; the pointer always wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            wp      <= '0;
            depth_q <= '0;
        end else begin
            pc_q <= pc_next;
            if (push) begin
                wp <= wp + 1'b1;
                if (!full) depth_q <= depth_q + 1'b1;
            end else if (pop) begin
                wp <= wp_dec;
                if (!empty) depth_q <= depth_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) stack_mem[wp] <= link_addr;
    end

    assign pc    = pc_q;
    assign depth = depth_q;

`ifdef PC_SEQ_STACK_ERR_EN
    logic ovf_q;
    logic udf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (push && full)   ovf_q <= 1'b1;
            else if (clr_err)   ovf_q <= 1'b0;
            if (pop && empty)   udf_q <= 1'b1;
            else if (clr_err)   udf_q <= 1'b0;
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
`else
    logic unused_clr_err;
    assign unused_clr_err = clr_err;
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random
// stimulus against a behavioural model of the sequencing rules.
module tb_pc_sequencer;

    localparam int AW = 16;
    localparam int SD = 16;
    localparam int JW = 13;
    localparam int IW = 3;
`ifdef PC_SEQ_STACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          jmp;
    logic [JW-1:0] jmp_target;
    logic          branch;
    logic [AW-1:0] branch_target;
    logic          call;
    logic [AW-1:0] call_target;
    logic          ret;
    logic          irq;
    logic [IW-1:0] irq_num;
    logic [AW-1:0] link_addr;
    logic          clr_err;
    logic [AW-1:0] pc;
    logic [4:0]    depth;
    logic          ovf;
    logic          udf;

    int vectors = 0;
    int miscompares = 0;

    logic [AW-1:0] m_mem [SD];
    int            m_ptr;
    int            m_depth;
    logic [AW-1:0] m_pc;
    logic          m_ovf;
    logic          m_udf;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .stall(stall),
        .jmp(jmp), .jmp_target(jmp_target),
        .branch(branch), .branch_target(branch_target),
        .call(call), .call_target(call_target),
        .ret(ret), .irq(irq), .irq_num(irq_num),
        .link_addr(link_addr), .clr_err(clr_err),
        .pc(pc), .depth(depth), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    task automatic idle();
        stall = 0; jmp = 0; branch = 0; call = 0;
        ret = 0; irq = 0; clr_err = 0;
        jmp_target = '0; branch_target = '0; call_target = '0;
        irq_num = '0; link_addr = '0;
    endtask

    task automatic model_reset();
        m_pc = '0; m_ptr = 0; m_depth = 0;
        m_ovf = 0; m_udf = 0;
    endtask

    task automatic model_push(input logic [AW-1:0] v, output bit ev);
        m_mem[m_ptr] = v;
        m_ptr = (m_ptr + 1) % SD;
        ev = (m_depth == SD);
        if (!ev) m_depth++;
    endtask

    // Apply current inputs to the model, then let the DUT take the edge.
    task automatic cycle();
        bit ovf_ev = 0;
        bit udf_ev = 0;
        if (irq) begin
            model_push(link_addr, ovf_ev);
            m_pc = AW'(irq_num);
        end else if (call) begin
            model_push(link_addr, ovf_ev);
            m_pc = call_target;
        end else if (branch) begin
            m_pc = branch_target;
        end else if (ret) begin
            m_ptr = (m_ptr + SD - 1) % SD;
            m_pc = m_mem[m_ptr];
            udf_ev = (m_depth == 0);
            if (!udf_ev) m_depth--;
        end else if (jmp) begin
            m_pc = AW'((int'(m_pc) / (1 << JW)) * (1 << JW) + int'(jmp_target));
        end else if (!stall) begin
            m_pc = AW'((int'(m_pc) + 1) % (1 << AW));
        end
        if (ERR_EN) begin
            if (ovf_ev) m_ovf = 1;
            else if (clr_err) m_ovf = 0;
            if (udf_ev) m_udf = 1;
            else if (clr_err) m_udf = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        vectors++;
        if (pc !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_pc got %h want 0000", pc);
        end
        vectors++;
        if (depth !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_depth got %0d want 0", depth);
        end
        vectors++;
        if (ovf !== 1'b0 || udf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags got ovf=%b udf=%b want 0 0", ovf, udf);
        end
    endtask

    task automatic test_increment();
        rst = 1'b0;
        vectors++;
        if (pc !== 16'h0000) begin
            miscompares++;
            $display("FAIL inc_start got %h want 0000", pc);
        end
        for (int i = 1; i < 5; i++) begin
            cycle();
            vectors++;
            if (pc !== 16'(i) || depth !== 5'd0) begin
                miscompares++;
                $display("FAIL inc_%0d got pc=%h depth=%0d want %h 0", i, pc, depth, 16'(i));
            end
        end
    endtask

    task automatic test_jmp_call_ret();
        idle(); branch = 1; branch_target = 16'h1234;
        cycle();
        idle(); jmp = 1; jmp_target = 13'h0042;
        cycle();
        vectors++;
        if (pc !== 16'h0042) begin
            miscompares++;
            $display("FAIL jmp got %h want 0042", pc);
        end
        idle(); call = 1; call_target = 16'h2000; link_addr = 16'h0043;
        cycle();
        vectors++;
        if (pc !== 16'h2000 || depth !== 5'd1) begin
            miscompares++;
            $display("FAIL call got pc=%h depth=%0d want 2000 1", pc, depth);
        end
        idle(); ret = 1;
        cycle();
        vectors++;
        if (pc !== 16'h0043 || depth !== 5'd0) begin
            miscompares++;
            $display("FAIL ret got pc=%h depth=%0d want 0043 0", pc, depth);
        end
        idle(); branch = 1; branch_target = 16'hE123;
        cycle();
        idle(); jmp = 1; jmp_target = 13'h0042;
        cycle();
        vectors++;
        if (pc !== 16'hE042) begin
            miscompares++;
            $display("FAIL jmp_page got %h want e042", pc);
        end
    endtask

    task automatic test_priority();
        idle();
        irq = 1; irq_num = 3'd5; call = 1; call_target = 16'h3333;
        ret = 1; stall = 1; link_addr = 16'hBEEF;
        cycle();
        vectors++;
        if (pc !== 16'h0005 || depth !== 5'd1) begin
            miscompares++;
            $display("FAIL irq_prio got pc=%h depth=%0d want 0005 1", pc, depth);
        end
        idle(); branch = 1; branch_target = 16'h7777; ret = 1; jmp = 1;
        cycle();
        vectors++;
        if (pc !== 16'h7777 || depth !== 5'd1) begin
            miscompares++;
            $display("FAIL branch_prio got pc=%h depth=%0d want 7777 1", pc, depth);
        end
        idle(); stall = 1;
        cycle();
        vectors++;
        if (pc !== 16'h7777) begin
            miscompares++;
            $display("FAIL stall got %h want 7777", pc);
        end
        idle(); ret = 1; stall = 1;
        cycle();
        vectors++;
        if (pc !== 16'hBEEF || depth !== 5'd0) begin
            miscompares++;
            $display("FAIL irq_link got pc=%h depth=%0d want beef 0", pc, depth);
        end
        idle(); call = 1; call_target = 16'h4000; link_addr = 16'h1111; ret = 1;
        cycle();
        idle(); ret = 1;
        cycle();
        vectors++;
        if (pc !== 16'h1111 || depth !== 5'd0) begin
            miscompares++;
            $display("FAIL call_ret got pc=%h depth=%0d want 1111 0", pc, depth);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) begin
            idle(); call = 1; call_target = 16'h2000 + 16'(i);
            link_addr = 16'h0100 + 16'(i);
            cycle();
            if (i == 15) begin
                vectors++;
                if (depth !== 5'd16 || ovf !== 1'b0) begin
                    miscompares++;
                    $display("FAIL full got depth=%0d ovf=%b want 16 0", depth, ovf);
                end
            end
        end
        vectors++;
        if (depth !== 5'd16 || ovf !== ERR_EN) begin
            miscompares++;
            $display("FAIL ovf got depth=%0d ovf=%b want 16 %b", depth, ovf, ERR_EN);
        end
        for (int i = 0; i < 16; i++) begin
            idle(); ret = 1;
            cycle();
            vectors++;
            if (pc !== 16'h0110 - 16'(i)) begin
                miscompares++;
                $display("FAIL ovf_ret_%0d got %h want %h", i, pc, 16'h0110 - 16'(i));
            end
        end
        vectors++;
        if (depth !== 5'd0 || udf !== 1'b0) begin
            miscompares++;
            $display("FAIL drained got depth=%0d udf=%b want 0 0", depth, udf);
        end
    endtask

    task automatic test_underflow();
        idle(); ret = 1;
        cycle();
        vectors++;
        if (pc !== 16'h0110 || depth !== 5'd0 || udf !== ERR_EN) begin
            miscompares++;
            $display("FAIL udf got pc=%h depth=%0d udf=%b want 0110 0 %b", pc, depth, udf, ERR_EN);
        end
        idle(); ret = 1; clr_err = 1;
        cycle();
        vectors++;
        if (udf !== ERR_EN || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL set_wins got udf=%b ovf=%b want %b 0", udf, ovf, ERR_EN);
        end
        idle(); clr_err = 1;
        cycle();
        vectors++;
        if (udf !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_err got udf=%b want 0", udf);
        end
        idle(); branch = 1; branch_target = 16'hFFFF;
        cycle();
        idle();
        cycle();
        vectors++;
        if (pc !== 16'h0000) begin
            miscompares++;
            $display("FAIL wrap got %h want 0000", pc);
        end
    endtask

    task automatic test_midreset();
        for (int i = 0; i < 3; i++) begin
            idle(); call = 1; call_target = 16'h5000; link_addr = 16'h0A00 + 16'(i);
            cycle();
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        vectors++;
        if (pc !== 16'h0000 || depth !== 5'd0 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst got pc=%h depth=%0d ovf=%b want 0000 0 0", pc, depth, ovf);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        cycle();
        vectors++;
        if (pc !== 16'h0001 || depth !== 5'd0) begin
            miscompares++;
            $display("FAIL midrst_rel got pc=%h depth=%0d want 0001 0", pc, depth);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            idle();
            if ($urandom_range(99) == 0) begin
                rst = 1'b1;
                #2;
                model_reset();
                vectors++;
                if (pc !== 16'h0000 || depth !== 5'd0) begin
                    miscompares++;
                    $display("FAIL rnd_rst got pc=%h depth=%0d", pc, depth);
                end
                rst = 1'b0;
            end
            irq    = ($urandom_range(9) == 0);
            call   = ($urandom_range(5) == 0);
            branch = ($urandom_range(6) == 0);
            ret    = ($urandom_range(3) == 0);
            jmp    = ($urandom_range(5) == 0);
            stall  = ($urandom_range(3) == 0);
            clr_err = ($urandom_range(7) == 0);
            irq_num = IW'($urandom);
            jmp_target = JW'($urandom);
            branch_target = AW'($urandom);
            call_target = AW'($urandom);
            link_addr = AW'($urandom);
            cycle();
            vectors++;
            if (pc !== m_pc || depth !== 5'(m_depth) || ovf !== m_ovf || udf !== m_udf) begin
                miscompares++;
                $display("FAIL rnd_%0d got pc=%h d=%0d o=%b u=%b want %h %0d %b %b",
                         n, pc, depth, ovf, udf, m_pc, m_depth, m_ovf, m_udf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_increment();
        test_jmp_call_ret();
        test_priority();
        test_overflow();
        test_underflow();
        test_midreset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
